inv_mix_state: RTL and testbench
================================

# inv_mix_state

Sequential AES InvMixColumns engine for the decryption datapath. Accepts a full 128-bit state on a start pulse, applies InvMixColumns one 32-bit column per clock, and returns the whole 128-bit result with a one-cycle done pulse. It reuses the column byte ordering of `mix_columns` and is its inverse: feeding it the forward `mix_columns` output for all four columns restores the original state.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `start`  input  1  request; sampled only while idle (`busy`=0).
- `data_in`  input  128  state to transform; column c = `data_in[127-32c -: 32]`; byte 0 of each column is its MSB byte.
- `data_out`  output  128  transformed state; same column and byte layout as `data_in`.
- `busy`  output  1  high while a transform is in progress.
- `done`  output  1  one-cycle pulse; `data_out` valid from this cycle onward.

## Operation
- State machine: IDLE, RUN.
- IDLE:
  - On `start`=1 at an edge: latch `data_in` into the 128-bit working register, clear the 2-bit column counter, go to RUN, assert `busy`.
- RUN:
  - Each edge computes InvMixColumns on the working-register column indexed by the counter and writes it back in place.
  - Counter advances 0→1→2→3.
  - On the edge that processes column 3: copy the completed working register to `data_out`, assert `done`, deassert `busy`, return to IDLE. The counter wraps to 0.
- Column math, with input bytes a0..a3 and all products in GF(2^8) mod 0x11B:
  - b0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3; the remaining rows are rotated.
  - Products are built from xtime chains: 2x, 4x, 8x, then 9 = 8^1, B = 8^2^1, D = 8^4^1, E = 8^4^2.
  - All operations are 8-bit; no carries.
- `start` while `busy`=1 is ignored. The in-flight operation is unaffected and no request is queued.
- `start` in the same cycle that `done` is high is accepted, because the FSM is already in IDLE.
- `data_out` changes only on the completing edge. It holds its value across IDLE and subsequent RUN phases until the next completion.
- `data_in` is ignored except at the accepting edge.

## Timing
- Reset values: `data_out`=0, `busy`=0, `done`=0, FSM=IDLE, counter=0, working register=0.
- Reset asserted mid-RUN aborts the operation on that edge:
  - no `done` is produced;
  - `data_out` returns to 0.
- Latency: with `start` accepted at edge k, columns 0..3 are processed at edges k+1..k+4.
  - `done` is high in the cycle following edge k+4, i.e. 4 cycles after acceptance.
- `busy` is high from edge k up to edge k+4, exactly 4 cycles.
- `done` is high for exactly one cycle and self-clears at the next edge unless another completion occurs.
- Minimum start-to-start spacing is 5 cycles.
- The combinational column path is one column wide. It lies only between the working register and itself.

## Configuration
- `INV_MIX_FWD_EN`: compiles in forward-mode support.
- Defined:
  - Adds input `enc` (1 bit), sampled with `start` and held internally for the operation.
  - `enc`=1 applies forward MixColumns: 02,03,01,01 rotated. `enc`=0 applies the inverse.
  - Timing is identical in both modes.
- Undefined:
  - The `enc` port does not exist.
  - The block always applies InvMixColumns and contains no forward-mode logic.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, release. Required: `data_out`=0, `busy`=0, `done`=0, and no `done` within 10 idle cycles.
- FIPS-197 vector:
  - Stimulus: `start` with `data_in`=128'h046681e5_e0cb199a_48f8d37a_2806264c.
  - Required: `done` exactly 4 cycles later; `data_out`=128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5; `busy` high for exactly 4 cycles.
- Round trip through `mix_columns`:
  - Stimulus: apply `mix_columns.mix_out_enc` per column to the states 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5 and 128'h305dbfd4_…_305dbfd4, then run the results through this block.
  - Required: the original states are returned.
- Start while busy:
  - Stimulus: start vector A, then pulse `start` with vector B at cycles +1 and +3.
  - Required: one `done` only, with the result of A; B is not processed.
- Back-to-back:
  - Stimulus: assert `start` with vector B in the cycle `done` for A is high.
  - Required: B is accepted; its `done` arrives 5 cycles after A's `done`; `data_out` holds A's result until then.
- Reset mid-operation:
  - Stimulus: assert `rst` 2 cycles after `start`.
  - Required: no `done`; `busy`=0 and `data_out`=0 after the reset edge. A following `start` completes normally.

Source files
------------

// File: rtl/inv_mix_state.sv
// Sequential AES (Inv)MixColumns engine: one 32-bit column per clock, 128-bit result with done pulse.
// Optional INV_MIX_FWD_EN adds an enc input selecting forward MixColumns per operation.
module inv_mix_state (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef INV_MIX_FWD_EN
  input  logic         enc,
`endif
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic [DW-1:0] work, work_nxt;
  logic [DW-1:0] data_out_nxt;
  logic          busy_nxt, done_nxt;
  logic [CW-1:0] col_in, col_out;
  logic [6:0]    col_base;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse column: 0E 0B 0D 09 in row 0, rotated for the other rows.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0]  a [4];
    logic [7:0]  m2 [4];
    logic [7:0]  m4 [4];
    logic [7:0]  m8 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                     ^ (m8[2'(i+1)] ^ m2[2'(i+1)] ^ a[2'(i+1)])
                     ^ (m8[2'(i+2)] ^ m4[2'(i+2)] ^ a[2'(i+2)])
                     ^ (m8[2'(i+3)] ^ a[2'(i+3)]);
    end
    return r;
  endfunction

`ifdef INV_MIX_FWD_EN
  logic enc_q, enc_nxt;

  // Forward column: 02 03 01 01 in row 0, rotated for the other rows.
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0]  a [4];
    logic [7:0]  m2 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
    end
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = m2[i] ^ m2[2'(i+1)] ^ a[2'(i+1)] ^ a[2'(i+2)] ^ a[2'(i+3)];
    end
    return r;
  endfunction
`endif

  // Column c occupies bits [127-32c -: 32], i.e. base 32*(3-c).
  assign col_base = {~cnt, 5'b00000};
  assign col_in   = work[col_base +: CW];

`ifdef INV_MIX_FWD_EN
  assign col_out = enc_q ? fwd_col(col_in) : inv_col(col_in);
`else
  assign col_out = inv_col(col_in);
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    work_nxt     = work;
    data_out_nxt = data_out;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
`ifdef INV_MIX_FWD_EN
    enc_nxt      = enc_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          work_nxt  = data_in;
          cnt_nxt   = 2'd0;
          busy_nxt  = 1'b1;
`ifdef INV_MIX_FWD_EN
          enc_nxt   = enc;
`endif
        end
      end
      RUN: begin
        work_nxt[col_base +: CW] = col_out;
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_nxt    = IDLE;
          data_out_nxt = work_nxt;
          done_nxt     = 1'b1;
          busy_nxt     = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      work     <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef INV_MIX_FWD_EN
      enc_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      work     <= work_nxt;
      data_out <= data_out_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
`ifdef INV_MIX_FWD_EN
      enc_q    <= enc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_inv_mix_state.sv
// Self-checking bench for inv_mix_state: directed cases plus random vectors against a GF(2^8) matrix model.
// Define INV_MIX_FWD_EN to also exercise forward mode through the enc port.
module tb_inv_mix_state;

  logic         clk;
  logic         rst;
  logic         start;
  logic         enc;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  inv_mix_state dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef INV_MIX_FWD_EN
    .enc      (enc),
`endif
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // State times the circulant matrix, column by column.
  function automatic logic [127:0] mix_state(input logic [127:0] s, input bit fwd);
    logic [7:0]   co [4];
    logic [7:0]   a  [4];
    logic [7:0]   b;
    logic [127:0] r = '0;
    if (fwd) begin co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01; end
    else     begin co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09; end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(co[(j - i + 4) % 4], a[j]);
        r[127 - 32*c - 8*i -: 8] = b;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents start for one edge; returns at the negedge right after the accepting edge.
  task automatic do_start(input logic [127:0] d, input logic e);
    @(negedge clk);
    start = 1'b1; data_in = d; enc = e;
    @(negedge clk);
    start = 1'b0; data_in = $urandom(); enc = $urandom_range(0, 1);
  endtask

  // One full operation: latency, busy length, single done, result.
  task automatic run_check(input string tag, input logic [127:0] d, input logic e,
                           input logic [127:0] exp);
    int first_done = 0;
    int n_done = 0;
    int n_busy = 0;
    logic [127:0] res = '0;
    do_start(d, e);
    for (int i = 1; i <= 12; i++) begin
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (first_done == 0) begin first_done = i; res = data_out; end
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, 128'(first_done - 1), 128'(4));
    check({tag, "_busy_cycles"}, 128'(n_busy), 128'(4));
    check({tag, "_done_count"}, 128'(n_done), 128'(1));
    check({tag, "_result"}, res, exp);
  endtask

  logic [127:0] va, vb, ra, rb, v;
  logic         ea, eb;
  int           nd;

  initial begin
    rst = 1'b1; start = 1'b0; enc = 1'b0; data_in = '0;
    // Reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_data_out", data_out, '0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    nd = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (done || busy) nd++; end
    check("idle_no_activity", 128'(nd), 128'(0));

    // FIPS-197 example column data
    check("model_fips", mix_state(128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b0),
          128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    run_check("fips", 128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b0,
              128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);

    // Round trip through the forward transform
    v = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    run_check("roundtrip0", mix_state(v, 1'b1), 1'b0, v);
    v = 128'h305dbfd4_305dbfd4_305dbfd4_305dbfd4;
    run_check("roundtrip1", mix_state(v, 1'b1), 1'b0, v);

    // Random vectors
    for (int t = 0; t < 8; t++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef INV_MIX_FWD_EN
      ea = 1'($urandom_range(0, 1));
`else
      ea = 1'b0;
`endif
      run_check("random", v, ea, mix_state(v, ea));
    end

    // Start while busy: B pulses at +1 and +3 are ignored
    va = {$urandom(), $urandom(), $urandom(), $urandom()};
    vb = ~va;
    ra = mix_state(va, 1'b0);
    do_start(va, 1'b0);
    nd = 0; v = '0;
    for (int i = 1; i <= 14; i++) begin
      if (done) begin nd++; v = data_out; end
      start = (i == 1 || i == 3);
      data_in = vb; enc = 1'b0;
      @(negedge clk);
      start = 1'b0;
    end
    check("busy_start_done_count", 128'(nd), 128'(1));
    check("busy_start_result", v, ra);

    // Back-to-back: B presented in A's done cycle
    va = {$urandom(), $urandom(), $urandom(), $urandom()};
    vb = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef INV_MIX_FWD_EN
    ea = 1'b0; eb = 1'b1;
`else
    ea = 1'b0; eb = 1'b0;
`endif
    ra = mix_state(va, ea);
    rb = mix_state(vb, eb);
    do_start(va, ea);
    nd = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) begin
        check("b2b_a_done", 128'(done), 128'(1));
        check("b2b_a_result", data_out, ra);
      end else if (i >= 6 && i <= 9) begin
        if (done) nd++;
        if (data_out !== ra) nd++;
      end else if (i == 10) begin
        check("b2b_b_done", 128'(done), 128'(1));
        check("b2b_b_result", data_out, rb);
      end else if (i > 10 && done) begin
        nd++;
      end
      start = (i == 5);
      data_in = vb; enc = eb;
      @(negedge clk);
      start = 1'b0;
    end
    check("b2b_hold_and_no_extra_done", 128'(nd), 128'(0));

    // Reset mid-operation
    va = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_start(va, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    check("midrst_data_out", data_out, '0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin if (done) nd++; @(negedge clk); end
    check("midrst_no_done", 128'(nd), 128'(0));
    run_check("after_rst", va, 1'b0, mix_state(va, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
